// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory access unit for the RV32I core. Accepts one load or store per
//   request, steers store data into byte lanes with byte enables, runs a
//   req/gnt/rvalid handshake to data memory and extends load data for
//   write-back. Illegal and misaligned accesses complete with rsp_err set and
//   never reach memory.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from execute (ready in IDLE only)
//   req_we, req_funct3         1 = store; access size/sign (B,H,W,BU,HU)
//   req_addr, req_wdata        byte address, store data (value in low bits)
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata, rsp_err         extended load result / error flag
//   mem_req, mem_gnt           memory request, held until granted
//   mem_we, mem_be, mem_addr   registered write enable, byte enables, word address
//   mem_wdata                  registered lane-replicated store data
//   mem_rvalid, mem_rdata      load data return
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Latched request fields still needed after acceptance.
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        acc_err;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;
  assign mem_req   = (state_q == S_REQ);
  assign rsp_valid = (state_q == S_RESP);

  // Request decode, evaluated on the raw inputs in the accept cycle.
  always_comb begin
    if (req_we) begin
      illegal = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    end

    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    acc_err = illegal | misaligned;

    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << req_addr[1:0];
          wdata_d = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << req_addr[1:0];
          wdata_d = {2{req_wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = req_wdata;
        end
      endcase
    end else begin
      be_d    = 4'b1111;
      wdata_d = '0;
    end
  end

  // Load extraction from the returned word using the latched size/offset.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = acc_err ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side and response registers are only non-zero in the state that
  // presents them, so they are loaded on entry and cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
            if (acc_err) begin
              rsp_err <= 1'b1;
            end else begin
              mem_we    <= req_we;
              mem_be    <= be_d;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_rdata <= ld_ext;
          end
        end
        default: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus
// randomized transactions. A behavioural model computes per-transaction
// results; the driver turns them into per-cycle expectations that a single
// negedge process compares against the DUT outputs.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle expectations written by the driver.
  logic        check_en = 1'b0;
  logic        e_ready, e_rsp_valid, e_err, e_mreq, e_mwe;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  // Observations recorded by the compare process.
  int unsigned cyc = 0;
  int unsigned obs_req_cnt = 0;
  int unsigned obs_rsp_cyc = 0;
  int unsigned rsp_cnt = 0;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic        obs_err;

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("rsp_err",   32'(rsp_err),   32'(e_err));
      chk("rsp_rdata", rsp_rdata,      e_rdata);
      chk("mem_req",   32'(mem_req),   32'(e_mreq));
      chk("mem_we",    32'(mem_we),    32'(e_mwe));
      chk("mem_be",    32'(mem_be),    32'(e_be));
      chk("mem_addr",  mem_addr,       e_addr);
      chk("mem_wdata", mem_wdata,      e_wdata);
    end
    if (mem_req) begin
      obs_req_cnt++;
      obs_be    = mem_be;
      obs_addr  = mem_addr;
      obs_wdata = mem_wdata;
    end
    if (rsp_valid) begin
      obs_rdata   = rsp_rdata;
      obs_err     = rsp_err;
      obs_rsp_cyc = cyc;
      rsp_cnt++;
    end
    cyc++;
  end

  // ---------------- behavioural model ----------------
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned fn = int'(f3);
    bit ill, mis;
    if (we) ill = (fn >= 4) || (fn == 3);
    else    ill = (fn == 3) || (fn >= 6);
    mis = ((fn == 1 || fn == 5) && (a % 2 != 0)) || (fn == 2 && (a % 4 != 0));
    return ill || mis;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    int unsigned v;
    if (!we) return 4'hF;
    case (int'(f3) % 4)
      0:       v = 1 << off;
      1:       v = 3 << off;
      default: v = 15;
    endcase
    return 4'(v);
  endfunction

  function automatic logic [31:0] model_wd(input logic we, input logic [2:0] f3, input logic [31:0] wd);
    if (!we) return 32'h0;
    case (int'(f3) % 4)
      0:       return (wd % 256) * 32'h01010101;
      1:       return (wd % 65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v = word >> (8 * (a % 4));
    case (int'(f3))
      0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic exp_zero(input logic ready);
    e_ready = ready; e_rsp_valid = 0; e_err = 0; e_rdata = 0;
    e_mreq = 0; e_mwe = 0; e_be = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic spurious();
    mem_gnt    = 1'($urandom % 2);
    mem_rvalid = 1'($urandom % 2);
    mem_rdata  = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    req_valid  = 0;
    req_we     = 1'($urandom % 2);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    spurious();
    exp_zero(1'b1);
    step();
  endtask

  int unsigned accept_cyc;

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned gd, input int unsigned rvd);
    logic        m_err = model_err(we, f3, addr);
    logic [3:0]  m_be  = model_be(we, f3, addr);
    logic [31:0] m_wd  = model_wd(we, f3, wd);
    logic [31:0] m_rd  = model_ld(f3, addr, rd);
    obs_req_cnt = 0;
    accept_cyc  = cyc;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    spurious();
    exp_zero(1'b1);
    step();
    req_valid = 0; req_we = 1'($urandom % 2); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (m_err) begin
      spurious();
      exp_zero(1'b0); e_rsp_valid = 1; e_err = 1;
      step();
    end else begin
      for (int unsigned g = 0; g <= gd; g++) begin
        exp_zero(1'b0);
        e_mreq = 1; e_mwe = we; e_be = m_be; e_addr = addr & 32'hFFFFFFFC; e_wdata = m_wd;
        mem_gnt    = (g == gd);
        mem_rvalid = 1'($urandom % 2);
        mem_rdata  = $urandom;
        step();
      end
      if (!we) begin
        for (int unsigned w = 0; w <= rvd; w++) begin
          exp_zero(1'b0);
          mem_gnt    = 1'($urandom % 2);
          mem_rvalid = (w == rvd);
          mem_rdata  = (w == rvd) ? rd : $urandom;
          step();
        end
      end
      spurious();
      exp_zero(1'b0); e_rsp_valid = 1; e_rdata = we ? 32'h0 : m_rd;
      step();
    end
    exp_zero(1'b1);
  endtask

  // ---------------- stimulus ----------------
  int unsigned rsp_before;

  initial begin
    rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #3;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err",   32'(rsp_err), 32'd0);
    chk("reset mem_req",   32'(mem_req), 32'd0);
    chk("reset mem_be",    32'(mem_be), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    step();
    rst_n = 1;
    exp_zero(1'b1);
    check_en = 1;
    idle_cycle(); idle_cycle();

    // SB 0x103
    do_txn(1, 3'b000, 32'h103, 32'hA5, $urandom, 0, 0);
    chk("sb mem_addr",  obs_addr, 32'h100);
    chk("sb mem_be",    32'(obs_be), 32'h8);
    chk("sb mem_wdata", obs_wdata, 32'hA5A5A5A5);
    chk("sb latency",   obs_rsp_cyc - accept_cyc, 2);
    chk("sb rdata",     obs_rdata, 32'h0);
    idle_cycle();

    // LB / LBU at 0x202, grant held off 3 cycles
    do_txn(0, 3'b000, 32'h202, $urandom, 32'h1280FF34, 3, 0);
    chk("lb req cycles", obs_req_cnt, 4);
    chk("lb rdata", obs_rdata, 32'hFFFFFF80);
    do_txn(0, 3'b100, 32'h202, $urandom, 32'h1280FF34, 3, 1);
    chk("lbu rdata", obs_rdata, 32'h00000080);

    // LH / LHU / LW
    do_txn(0, 3'b001, 32'h302, $urandom, 32'h80017FFF, 0, 0);
    chk("lh rdata", obs_rdata, 32'hFFFF8001);
    do_txn(0, 3'b101, 32'h302, $urandom, 32'h80017FFF, 0, 2);
    chk("lhu rdata", obs_rdata, 32'h00008001);
    do_txn(0, 3'b010, 32'h300, $urandom, 32'h80017FFF, 0, 0);
    chk("lw rdata", obs_rdata, 32'h80017FFF);
    chk("lw latency", obs_rsp_cyc - accept_cyc, 3);

    // Misaligned / illegal
    do_txn(1, 3'b010, 32'h401, $urandom, $urandom, 0, 0);
    chk("sw mis err", 32'(obs_err), 32'd1);
    chk("sw mis req", obs_req_cnt, 0);
    chk("sw mis latency", obs_rsp_cyc - accept_cyc, 1);
    do_txn(0, 3'b001, 32'h403, $urandom, $urandom, 0, 0);
    chk("lh mis err", 32'(obs_err), 32'd1);
    chk("lh mis req", obs_req_cnt, 0);
    do_txn(1, 3'b100, 32'h500, $urandom, $urandom, 0, 0);
    chk("st f3=100 err", 32'(obs_err), 32'd1);
    chk("st f3=100 req", obs_req_cnt, 0);
    idle_cycle();

    // Reset while a load waits for rvalid
    check_en = 0;
    rsp_before = rsp_cnt;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h20;
    mem_gnt = 0; mem_rvalid = 0;
    step();
    req_valid = 0; mem_gnt = 1;
    step();
    mem_gnt = 0;
    #2 rst_n = 0;
    #1;
    chk("rst wait req_ready", 32'(req_ready), 32'd1);
    chk("rst wait rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst wait rsp_err",   32'(rsp_err), 32'd0);
    chk("rst wait mem_req",   32'(mem_req), 32'd0);
    chk("rst wait mem_we",    32'(mem_we), 32'd0);
    chk("rst wait mem_be",    32'(mem_be), 32'd0);
    chk("rst wait mem_addr",  mem_addr, 32'd0);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    step(); step();
    mem_rvalid = 0;
    rst_n = 1;
    step(); step();
    chk("rst no rsp", rsp_cnt - rsp_before, 0);
    exp_zero(1'b1);
    check_en = 1;
    do_txn(1, 3'b010, 32'h10, 32'h12345678, $urandom, 0, 0);
    chk("post-rst sw latency", obs_rsp_cyc - accept_cyc, 2);
    chk("post-rst sw wdata", obs_wdata, 32'h12345678);
    chk("post-rst sw addr",  obs_addr, 32'h10);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      do_txn(1'($urandom % 2), 3'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle_cycle();
    end
    idle_cycle();
    check_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
